// File: rtl/simple_bus_rr_arbiter.sv
// simple_bus_rr_arbiter: round-robin owner of the shared simple_bus signal `a`
// with a one-cycle handoff gap and a per-tenure hold limit.
module simple_bus_rr_arbiter #(
    parameter int NUM_REQ  = 10,
    parameter int MAX_HOLD = 8,
    parameter int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] a_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_valid_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               bus_a_o,
    output logic               preempt_o
);
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, HANDOFF} state_t;

    state_t             r_state, w_next;
    logic [IDX_W-1:0]   r_ptr, w_win;
    logic [CNT_W-1:0]   r_cnt, w_cnt_inc;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic               w_others, w_release, w_expire, w_preempt;

    // Scan from pointer+1 downwards in priority so the closest requester wins.
    always_comb begin
        w_win = '0;
        for (int i = NUM_REQ; i >= 1; i--)
            if (req_i[(int'(r_ptr) + i) % NUM_REQ]) w_win = IDX_W'((int'(r_ptr) + i) % NUM_REQ);
    end

    assign w_owner_oh = NUM_REQ'(1) << gnt_idx_o;
    assign w_others   = |(req_i & ~w_owner_oh);
    assign w_release  = !req_i[gnt_idx_o];
    assign w_cnt_inc  = (r_cnt == CNT_W'(MAX_HOLD)) ? r_cnt : r_cnt + 1'b1;
    assign w_expire   = (MAX_HOLD != 0) && (w_cnt_inc == CNT_W'(MAX_HOLD)) && w_others;

    always_comb begin
        w_next    = r_state;
        w_preempt = 1'b0;
        case (r_state)
            IDLE:    w_next = |req_i ? GRANT : IDLE;
            GRANT: begin
                if (w_release) begin
                    w_next = HANDOFF;
                end else if (w_expire) begin
                    w_next    = HANDOFF;
                    w_preempt = 1'b1;
                end
            end
            HANDOFF: w_next = |req_i ? GRANT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // r_cnt counts completed GRANT cycles of the current tenure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_o     <= '0;
            gnt_idx_o <= '0;
            preempt_o <= 1'b0;
            r_cnt     <= '0;
            r_ptr     <= IDX_W'(NUM_REQ - 1);
        end else begin
            preempt_o <= w_preempt;
            if (w_next == GRANT && r_state != GRANT) begin
                gnt_o     <= NUM_REQ'(1) << w_win;
                gnt_idx_o <= w_win;
                r_ptr     <= w_win;
                r_cnt     <= '0;
            end else if (w_next == GRANT) begin
                r_cnt <= w_cnt_inc;
            end else begin
                gnt_o <= '0;
            end
        end
    end

    assign gnt_valid_o = (r_state == GRANT);
    assign bus_a_o     = gnt_valid_o & a_i[gnt_idx_o];
endmodule

// File: tb/tb_simple_bus_rr_arbiter.sv
// tb_simple_bus_rr_arbiter: directed and random requests against a tenure-level
// model; expected outputs are queued per cycle and checked by a separate monitor.
module tb_simple_bus_rr_arbiter;
    localparam int N  = 10;
    localparam int MH = 8;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_i = '0;
    logic [N-1:0]  a_i = '0;
    logic [N-1:0]  gnt_o;
    logic          gnt_valid_o;
    logic [IW-1:0] gnt_idx_o;
    logic          bus_a_o;
    logic          preempt_o;

    simple_bus_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .a_i(a_i), .gnt_o(gnt_o),
        .gnt_valid_o(gnt_valid_o), .gnt_idx_o(gnt_idx_o), .bus_a_o(bus_a_o),
        .preempt_o(preempt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  gnt;
        logic          gv;
        logic [IW-1:0] idx;
        logic          bus;
        logic          pre;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Model: mode 0 = idle, 1 = owner holds the bus, 2 = turnaround gap.
    int m_mode = 0;
    int m_idx = 0;
    int m_ptr = N - 1;
    int m_held = 0;
    bit m_pre = 0;

    function automatic int search(int ptr, logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic start_tenure();
        m_idx  = search(m_ptr, req_i);
        m_ptr  = m_idx;
        m_held = 1;
        m_mode = 1;
    endtask

    task automatic model_step();
        logic [N-1:0] others;
        m_pre = 0;
        if (!rst_n) begin
            m_mode = 0; m_idx = 0; m_ptr = N - 1; m_held = 0;
        end else if (m_mode == 0) begin
            if (req_i != 0) start_tenure();
        end else if (m_mode == 1) begin
            others = req_i;
            others[m_idx] = 1'b0;
            if (!req_i[m_idx]) begin
                m_mode = 2;
            end else if (MH != 0 && m_held >= MH && others != 0) begin
                m_mode = 2;
                m_pre  = 1;
            end else begin
                m_held++;
            end
        end else begin
            if (req_i != 0) start_tenure();
            else m_mode = 0;
        end
    endtask

    task automatic drive(int n, logic [N-1:0] r, logic rs);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            req_i = r;
            rst_n = rs;
            a_i   = N'($urandom);
            e.gnt = (m_mode == 1) ? (N'(1) << m_idx) : '0;
            e.gv  = (m_mode == 1);
            e.idx = IW'(m_idx);
            e.bus = (m_mode == 1) && a_i[m_idx];
            e.pre = m_pre;
            q.push_back(e);
        end
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("gnt_o", 32'(gnt_o), 32'(e.gnt));
                check("gnt_valid_o", 32'(gnt_valid_o), 32'(e.gv));
                check("gnt_idx_o", 32'(gnt_idx_o), 32'(e.idx));
                check("bus_a_o", 32'(bus_a_o), 32'(e.bus));
                check("preempt_o", 32'(preempt_o), 32'(e.pre));
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        drive(2, '0, 1'b0);
        drive(5, 10'h001, 1'b1);
        drive(95, 10'h3FF, 1'b1);
        drive(3, '0, 1'b1);
        drive(50, 10'h020, 1'b1);
        drive(12, 10'h024, 1'b1);
        drive(3, '0, 1'b1);
        drive(2, 10'h008, 1'b1);
        drive(1, 10'h088, 1'b1);
        drive(5, 10'h080, 1'b1);
        drive(3, '0, 1'b1);
        drive(4, 10'h008, 1'b1);
        drive(4, '0, 1'b1);
        drive(1, 10'h001, 1'b1);
        drive(7, 10'h011, 1'b1);
        drive(3, 10'h010, 1'b1);
        drive(3, '0, 1'b1);
        drive(3, 10'h300, 1'b1);
        drive(1, 10'h300, 1'b0);
        drive(15, 10'h300, 1'b1);
        r = '0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3) == 0)
                r = N'($urandom) & N'($urandom) & ($urandom_range(1) == 1 ? N'($urandom) : '1);
            drive(1, r, ($urandom_range(299) != 0));
        end
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/simple_bus_rr_arbiter.md
Name: simple_bus_rr_arbiter

Overview:
Round-robin arbiter that shares one simple_bus instance (single-bit signal `a`, consumed through modport mp) among NUM_REQ requesters. The requesters are produced by a generate loop, one per loop index. The block registers a one-hot grant, muxes the owner's `a` onto the shared bus, and enforces a per-tenure hold limit with forced rotation. It sits at top level between the generate-block requester array and the shared bus interface.

Parameters:
NUM_REQ, 10, number of requesters (2..32).
MAX_HOLD, 8, maximum consecutive GRANT cycles per owner before forced rotation when others are waiting; 0 = unlimited.
IDX_W, $clog2(NUM_REQ), width of the owner index.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
req_i  input  NUM_REQ  per-requester request; held high while the requester wants the bus.
a_i  input  NUM_REQ  per-requester value for bus signal `a`.
gnt_o  output  NUM_REQ  registered one-hot grant; all-zero when no owner.
gnt_valid_o  output  1  high while in GRANT.
gnt_idx_o  output  IDX_W  index of the current owner; holds the last owner when not in GRANT.
bus_a_o  output  1  drives simple_bus.a: a_i[gnt_idx_o] in GRANT, else 0 (combinational from registered index).
preempt_o  output  1  one-cycle pulse on forced rotation.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; gnt_o=0, gnt_valid_o=0, gnt_idx_o=0, preempt_o=0.
  - hold counter=0; rr pointer=NUM_REQ-1, so the first search starts at index 0.
  - Reset mid-tenure drops the grant on the same edge. No handoff cycle is inserted.
- RR search: the first set bit of req_i scanning pointer+1, pointer+2, ... wrapping modulo NUM_REQ. The pointer is updated to the winner on every grant.
- States:
  - IDLE: if |req_i → GRANT to the search winner next edge (1-cycle latency req→gnt). Else stay.
  - GRANT:
    - Counter increments each cycle, saturating at MAX_HOLD.
    - If req_i[owner]=0 → HANDOFF, preempt_o=0.
    - Else if MAX_HOLD!=0, counter==MAX_HOLD, and any other req set → HANDOFF, preempt_o=1 for exactly that one cycle.
    - Else stay. A lone requester keeps the bus indefinitely; the counter stays saturated.
  - HANDOFF: exactly one cycle, gnt_o=0, bus_a_o=0 (bus turnaround gap).
    - Next edge: if |req_i → GRANT to the search winner (pointer = last owner, so the preempted owner is searched last). Else IDLE.
    - Counter clears on entry to GRANT.
- Timing and priority:
  - Requests arriving during GRANT or HANDOFF are sampled only at the HANDOFF→GRANT or IDLE→GRANT decision edges.
  - Simultaneous owner release and hold expiry: treated as a release, no preempt pulse.
  - The owner may re-win only if it is the sole requester at the decision edge.
- gnt_o is always one-hot or zero; gnt_o[gnt_idx_o]==gnt_valid_o at every cycle.

Test Plan:
1. Reset; req_i=0x001 at cycle 0 → gnt_o=0x001, gnt_idx_o=0, gnt_valid_o=1 at cycle 1; bus_a_o follows a_i[0].
2. req_i=0x3FF held, MAX_HOLD=8:
   - grant order 0,1,2,…,9,0 with 8 GRANT cycles + 1 HANDOFF cycle each;
   - preempt_o pulses once per rotation;
   - gnt_o=0 and bus_a_o=0 in every HANDOFF cycle.
3. Sole requester 5 held 50 cycles → gnt_idx_o=5 throughout, no preempt. Requester 2 then rises:
   - preempt on the next cycle;
   - the following GRANT goes to 2 (search wraps 6..9,0,1,2).
4. Owner 3 drops req after 2 cycles while 7 is pending → HANDOFF, preempt_o=0, then grant 7. With no one pending, HANDOFF→IDLE and gnt_idx_o stays 3.
5. Owner releases on the same cycle its counter hits MAX_HOLD → preempt_o stays 0.
6. rst_n=0 for one cycle mid-GRANT:
   - all outputs zero next edge;
   - with req_i=0x300 held after reset, the first grant goes to 8 (search from 0).
